// File: rtl/pipe_stream_router.sv
// pipe_stream_router
// Parses the host block-pipe stream into framed packets (header + LEN words)
// and steers payload words into NUM_CH first-word-fall-through channel FIFOs.
// Pipe-out reads return round-robin per-channel status words so the host can
// pace downloads.
//
// Ports:
//   okClk        clock (front-panel domain)
//   mst_reset    asynchronous active-high reset
//   ep_write     pipe-in strobe, ep_dataout valid
//   ep_dataout   pipe-in data word
//   ep_read      pipe-out strobe, current ep_datain consumed
//   ep_datain    registered status word {5, ch, ovf, 0, count}
//   ch_data      per-channel FIFO head word, channel i at [32*i +: 32]
//   ch_valid     per-channel FIFO non-empty
//   ch_ready     per-channel consumer pop request
//   busy         parser is inside a packet (PAYLOAD or DISCARD)
//   hdr_err_cnt  saturating count of rejected header words
module pipe_stream_router #(
   parameter int unsigned NUM_CH = 2,
   parameter int unsigned DEPTH  = 512
) (
   input  logic                   okClk,
   input  logic                   mst_reset,
   input  logic                   ep_write,
   input  logic [31:0]            ep_dataout,
   input  logic                   ep_read,
   output logic [31:0]            ep_datain,
   output logic [32*NUM_CH-1:0]   ch_data,
   output logic [NUM_CH-1:0]      ch_valid,
   input  logic [NUM_CH-1:0]      ch_ready,
   output logic                   busy,
   output logic [15:0]            hdr_err_cnt
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [4:0]       NUM_CH_HDR = 5'(NUM_CH);
   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);

   localparam logic [1:0] ST_HDR     = 2'd0;
   localparam logic [1:0] ST_PAYLOAD = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;

   // Parser state
   logic [1:0]       state_q, state_d;
   logic [CH_W-1:0]  ch_q, ch_d;
   logic [15:0]      rem_q, rem_d;
   logic [15:0]      err_q, err_d;
   logic             busy_q, busy_d;
   logic             payload_wr;

   // Status read-out state
   logic [CH_W-1:0]  rd_idx_q, rd_idx_d;
   logic [NUM_CH-1:0] ovf_q, ovf_d;
   logic [31:0]      datain_q, datain_d;

   // Channel FIFO state
   logic [NUM_CH-1:0] valid_q, valid_d;
   logic [31:0]      head_q   [NUM_CH];
   logic [31:0]      head_d   [NUM_CH];
   logic [AW-1:0]    wr_ptr_q [NUM_CH];
   logic [AW-1:0]    wr_ptr_d [NUM_CH];
   logic [AW-1:0]    rd_ptr_q [NUM_CH];
   logic [AW-1:0]    rd_ptr_d [NUM_CH];
   logic [CNT_W-1:0] count_q  [NUM_CH];
   logic [CNT_W-1:0] count_d  [NUM_CH];
   logic [31:0]      mem_q    [NUM_CH][DEPTH];

   logic [NUM_CH-1:0] push_req, push_acc, pop;

   // Header field decode
   logic        hdr_magic_ok;
   logic [3:0]  hdr_ch;
   logic [15:0] hdr_len;
   logic        hdr_ch_ok;

   assign hdr_magic_ok = (ep_dataout[31:28] == 4'hA);
   assign hdr_ch       = ep_dataout[27:24];
   assign hdr_len      = ep_dataout[15:0];
   assign hdr_ch_ok    = ({1'b0, hdr_ch} < NUM_CH_HDR);

   // Parser next state: only ep_write cycles advance the FSM
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      rem_d      = rem_q;
      err_d      = err_q;
      payload_wr = 1'b0;
      if (ep_write) begin
         case (state_q)
            ST_HDR: begin
               if (!hdr_magic_ok) begin
                  err_d = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
               end else if (hdr_len != 16'd0) begin
                  rem_d = hdr_len;
                  if (hdr_ch_ok) begin
                     ch_d    = CH_W'(hdr_ch);
                     state_d = ST_PAYLOAD;
                  end else begin
                     err_d   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
                     state_d = ST_DISCARD;
                  end
               end
            end
            ST_PAYLOAD: begin
               payload_wr = 1'b1;
               rem_d      = rem_q - 16'd1;
               if (rem_q == 16'd1) state_d = ST_HDR;
            end
            ST_DISCARD: begin
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
         endcase
      end
      busy_d = (state_d != ST_HDR);
   end

   // FIFO push/pop, head-word and overflow next state per channel
   always_comb begin
      push_req = '0;
      push_acc = '0;
      pop      = '0;
      valid_d  = '0;
      ovf_d    = ovf_q;
      for (int i = 0; i < NUM_CH; i++) begin
         head_d[i]   = head_q[i];
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         count_d[i]  = count_q[i];

         push_req[i] = payload_wr && (ch_q == CH_W'(i));
         pop[i]      = valid_q[i] & ch_ready[i];
         // A full FIFO still takes the word if it frees a slot this cycle
         push_acc[i] = push_req[i] && ((count_q[i] != DEPTH_CNT) || pop[i]);

         if (push_acc[i]) wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
         if (pop[i])      rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
         count_d[i] = count_q[i] + CNT_W'(push_acc[i]) - CNT_W'(pop[i]);
         valid_d[i] = (count_d[i] != '0);

         // Head register mirrors mem[rd_ptr] so ch_data comes straight from a flop
         if (pop[i] && (count_q[i] > CNT_W'(1))) begin
            head_d[i] = mem_q[i][rd_ptr_q[i] + AW'(1)];
         end else if (push_acc[i] && ((count_q[i] == '0) || pop[i])) begin
            head_d[i] = ep_dataout;
         end else if (pop[i]) begin
            head_d[i] = '0;
         end

         // Overflow set takes priority over the clear-on-read
         if (ep_read && (rd_idx_q == CH_W'(i))) ovf_d[i] = 1'b0;
         if (push_req[i] && !push_acc[i])       ovf_d[i] = 1'b1;
      end
   end

   // Status pointer and the status word for the channel it will point at
   always_comb begin
      rd_idx_d = rd_idx_q;
      if (ep_read) begin
         rd_idx_d = (rd_idx_q == CH_W'(NUM_CH - 1)) ? '0 : rd_idx_q + CH_W'(1);
      end
      datain_d = {4'h5, 4'(rd_idx_d), ovf_d[rd_idx_d], 7'd0, 16'(count_d[rd_idx_d])};
   end

   // State registers
   always_ff @(posedge okClk or posedge mst_reset) begin
      if (mst_reset) begin
         state_q  <= ST_HDR;
         ch_q     <= '0;
         rem_q    <= '0;
         err_q    <= '0;
         busy_q   <= 1'b0;
         rd_idx_q <= '0;
         ovf_q    <= '0;
         datain_q <= 32'h5000_0000;
         valid_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            head_q[i]   <= '0;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         ch_q     <= ch_d;
         rem_q    <= rem_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         rd_idx_q <= rd_idx_d;
         ovf_q    <= ovf_d;
         datain_q <= datain_d;
         valid_q  <= valid_d;
         for (int i = 0; i < NUM_CH; i++) begin
            head_q[i]   <= head_d[i];
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
      end
   end

   // FIFO storage; contents are don't-care while empty, so no reset
   always_ff @(posedge okClk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push_acc[i]) mem_q[i][wr_ptr_q[i]] <= ep_dataout;
      end
   end

   // Output mapping
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch_out
      assign ch_data[32*g +: 32] = head_q[g];
   end

   assign ch_valid    = valid_q;
   assign busy        = busy_q;
   assign hdr_err_cnt = err_q;
   assign ep_datain   = datain_q;

endmodule

// File: tb/tb_pipe_stream_router.sv
// Testbench for pipe_stream_router: table-driven routing/bad-header vectors
// plus directed sequences for overflow, simultaneous events, round-robin
// status and mid-packet reset.
module tb_pipe_stream_router;

   logic        okClk = 1'b0;
   logic        mst_reset;
   logic        wr, rd;
   logic [31:0] din;
   logic [1:0]  rdy;
   logic [31:0] datain;
   logic [63:0] chd;
   logic [1:0]  chv;
   logic        busy;
   logic [15:0] err;

   logic        rd3;
   logic [31:0] datain3;
   logic [95:0] chd3;
   logic [2:0]  chv3;
   logic        busy3;
   logic [15:0] err3;

   int total = 0;
   int passed = 0;

   always #5 okClk = ~okClk;

   pipe_stream_router #(.NUM_CH(2), .DEPTH(8)) dut (
      .okClk(okClk), .mst_reset(mst_reset),
      .ep_write(wr), .ep_dataout(din), .ep_read(rd), .ep_datain(datain),
      .ch_data(chd), .ch_valid(chv), .ch_ready(rdy),
      .busy(busy), .hdr_err_cnt(err)
   );

   pipe_stream_router #(.NUM_CH(3), .DEPTH(8)) dut3 (
      .okClk(okClk), .mst_reset(mst_reset),
      .ep_write(1'b0), .ep_dataout(32'h0), .ep_read(rd3), .ep_datain(datain3),
      .ch_data(chd3), .ch_valid(chv3), .ch_ready(3'b000),
      .busy(busy3), .hdr_err_cnt(err3)
   );

   typedef struct {
      logic        wr;
      logic [31:0] din;
      logic        rd;
      logic [1:0]  rdy;
      logic [1:0]  e_valid;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic        e_busy;
      logic [15:0] e_err;
      logic [31:0] e_datain;
   } vec_t;

   vec_t vt [18];

   function automatic vec_t mk(input logic w, input logic [31:0] d, input logic r,
                               input logic [1:0] y, input logic [1:0] ev,
                               input logic [31:0] e0, input logic [31:0] e1,
                               input logic eb, input logic [15:0] ee,
                               input logic [31:0] edi);
      vec_t v;
      v.wr = w; v.din = d; v.rd = r; v.rdy = y; v.e_valid = ev;
      v.e_d0 = e0; v.e_d1 = e1; v.e_busy = eb; v.e_err = ee; v.e_datain = edi;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passed++;
   endtask

   // Drive one cycle of inputs, sample #1 after the edge, then idle the inputs
   task automatic cyc(input logic w, input logic [31:0] d, input logic r, input logic [1:0] y);
      wr = w; din = d; rd = r; rdy = y;
      @(posedge okClk);
      #1;
      wr = 1'b0; din = '0; rd = 1'b0; rdy = '0;
   endtask

   task automatic do_reset();
      mst_reset = 1'b1;
      @(posedge okClk);
      #1;
      mst_reset = 1'b0;
   endtask

   initial begin
      mst_reset = 1'b1;
      wr = 1'b0; din = '0; rd = 1'b0; rdy = '0; rd3 = 1'b0;

      vt[0]  = mk(1, 32'hA100_0003, 0, 2'b00, 2'b00, 0, 0,      1, 0, 32'h5000_0000);
      vt[1]  = mk(1, 32'd11,        0, 2'b00, 2'b10, 0, 32'd11, 1, 0, 32'h5000_0000);
      vt[2]  = mk(1, 32'd22,        0, 2'b00, 2'b10, 0, 32'd11, 1, 0, 32'h5000_0000);
      vt[3]  = mk(1, 32'd33,        0, 2'b00, 2'b10, 0, 32'd11, 0, 0, 32'h5000_0000);
      vt[4]  = mk(0, 32'h0,         1, 2'b00, 2'b10, 0, 32'd11, 0, 0, 32'h5100_0003);
      vt[5]  = mk(0, 32'h0,         0, 2'b10, 2'b10, 0, 32'd22, 0, 0, 32'h5100_0002);
      vt[6]  = mk(0, 32'h0,         0, 2'b10, 2'b10, 0, 32'd33, 0, 0, 32'h5100_0001);
      vt[7]  = mk(0, 32'h0,         0, 2'b10, 2'b00, 0, 0,      0, 0, 32'h5100_0000);
      vt[8]  = mk(0, 32'h0,         1, 2'b00, 2'b00, 0, 0,      0, 0, 32'h5000_0000);
      vt[9]  = mk(1, 32'h1234_5678, 0, 2'b00, 2'b00, 0, 0,      0, 1, 32'h5000_0000);
      vt[10] = mk(1, 32'hA500_0002, 0, 2'b00, 2'b00, 0, 0,      1, 2, 32'h5000_0000);
      vt[11] = mk(1, 32'h77,        0, 2'b00, 2'b00, 0, 0,      1, 2, 32'h5000_0000);
      vt[12] = mk(1, 32'h88,        0, 2'b00, 2'b00, 0, 0,      0, 2, 32'h5000_0000);
      vt[13] = mk(1, 32'hA000_0001, 0, 2'b00, 2'b00, 0, 0,      1, 2, 32'h5000_0000);
      vt[14] = mk(1, 32'h99,        0, 2'b00, 2'b01, 32'h99, 0, 0, 2, 32'h5000_0001);
      vt[15] = mk(0, 32'h0,         0, 2'b01, 2'b00, 0, 0,      0, 2, 32'h5000_0000);
      vt[16] = mk(1, 32'hA000_0000, 0, 2'b00, 2'b00, 0, 0,      0, 2, 32'h5000_0000);
      vt[17] = mk(1, 32'h5,         0, 2'b00, 2'b00, 0, 0,      0, 3, 32'h5000_0000);

      // Reset values
      @(posedge okClk);
      #1;
      chk("rst_valid", 32'(chv), 32'h0);
      chk("rst_data", chd[31:0] | chd[63:32], 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_datain", datain, 32'h5000_0000);
      chk("rst_datain3", datain3, 32'h5000_0000);
      mst_reset = 1'b0;

      // Routing and bad-header vectors
      for (int i = 0; i < 18; i++) begin
         cyc(vt[i].wr, vt[i].din, vt[i].rd, vt[i].rdy);
         chk($sformatf("v%0d_valid", i), 32'(chv), 32'(vt[i].e_valid));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vt[i].e_busy));
         chk($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].e_err));
         chk($sformatf("v%0d_datain", i), datain, vt[i].e_datain);
         if (vt[i].e_valid[0]) chk($sformatf("v%0d_d0", i), chd[31:0], vt[i].e_d0);
         if (vt[i].e_valid[1]) chk($sformatf("v%0d_d1", i), chd[63:32], vt[i].e_d1);
      end

      // Overflow: 10 words into a depth-8 FIFO with no consumer
      do_reset();
      cyc(1, 32'hA000_000A, 0, 2'b00);
      for (int k = 1; k <= 10; k++) cyc(1, 32'(k), 0, 2'b00);
      chk("ovf_busy", 32'(busy), 32'h0);
      chk("ovf_valid", 32'(chv), 32'h1);
      chk("ovf_head", chd[31:0], 32'd1);
      chk("ovf_status", datain, 32'h5080_0008);
      cyc(0, 0, 1, 2'b00);
      chk("ovf_status_ch1", datain, 32'h5100_0000);
      cyc(0, 0, 1, 2'b00);
      chk("ovf_cleared", datain, 32'h5000_0008);

      // Push and pop on the full FIFO in the same cycle
      cyc(1, 32'hA000_0002, 0, 2'b00);
      cyc(1, 32'd100, 0, 2'b01);
      chk("sim_status", datain, 32'h5000_0008);
      chk("sim_head", chd[31:0], 32'd2);
      // Overflow coinciding with the clear-on-read of channel 0
      cyc(1, 32'd101, 1, 2'b00);
      chk("sim_busy", 32'(busy), 32'h0);
      chk("sim_status_ch1", datain, 32'h5100_0000);
      cyc(0, 0, 1, 2'b00);
      chk("sim_ovf_wins", datain, 32'h5080_0008);
      for (int j = 0; j < 8; j++) begin
         logic [31:0] exp_w;
         exp_w = (j < 7) ? 32'(j + 2) : 32'd100;
         chk($sformatf("drain%0d_valid", j), 32'(chv[0]), 32'h1);
         chk($sformatf("drain%0d_data", j), chd[31:0], exp_w);
         cyc(0, 0, 0, 2'b01);
      end
      chk("drain_empty", 32'(chv), 32'h0);

      // Round-robin status on the three-channel instance
      for (int j = 0; j < 4; j++) begin
         logic [3:0] exp_ch;
         exp_ch = (j == 2) ? 4'd2 : ((j == 1) ? 4'd1 : 4'd0);
         chk($sformatf("rr%0d_ch", j), 32'(datain3[27:24]), 32'(exp_ch));
         rd3 = 1'b1;
         @(posedge okClk);
         #1;
         rd3 = 1'b0;
      end

      // Reset in the middle of a packet
      do_reset();
      cyc(1, 32'h1234_0000, 0, 2'b00);
      cyc(1, 32'hA100_0005, 0, 2'b00);
      cyc(1, 32'd7, 0, 2'b00);
      cyc(1, 32'd8, 0, 2'b00);
      chk("mid_busy", 32'(busy), 32'h1);
      chk("mid_valid", 32'(chv), 32'h2);
      chk("mid_err", 32'(err), 32'h1);
      mst_reset = 1'b1;
      #2;
      chk("arst_valid", 32'(chv), 32'h0);
      chk("arst_busy", 32'(busy), 32'h0);
      chk("arst_err", 32'(err), 32'h0);
      chk("arst_datain", datain, 32'h5000_0000);
      @(posedge okClk);
      #1;
      mst_reset = 1'b0;
      cyc(1, 32'hA000_0001, 0, 2'b00);
      chk("post_busy", 32'(busy), 32'h1);
      cyc(1, 32'd42, 0, 2'b00);
      chk("post_valid", 32'(chv), 32'h1);
      chk("post_data", chd[31:0], 32'd42);
      chk("post_busy_lo", 32'(busy), 32'h0);
      chk("post_status", datain, 32'h5000_0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pipe_stream_router.md
# pipe_stream_router

Parametrised pipe-to-channel router between the front-panel USB endpoints and the sound-generator datapath. It parses the host block-pipe stream (ep_write/ep_dataout) into framed packets and steers payload words into one of NUM_CH first-word-fall-through channel FIFOs. It also answers pipe-out reads (ep_read/ep_datain) with round-robin per-channel status words. This lets the host pace downloads without extra wire-ins.

## Interface
Parameters:
- NUM_CH, 2: number of output channels (1..16).
- DEPTH, 512: words per channel FIFO; power of two, 4..32768.

Ports:
- okClk  in  1  sole clock, front-panel clock domain.
- mst_reset  in  1  reset, asynchronous, active-high.
- ep_write  in  1  pipe-in strobe; ep_dataout is valid this cycle.
- ep_dataout  in  32  pipe-in data word.
- ep_read  in  1  pipe-out strobe; current ep_datain is consumed this cycle.
- ep_datain  out  32  registered status word for the host.
- ch_data  out  32*NUM_CH  channel i occupies [32*i +: 32]; FIFO head word.
- ch_valid  out  NUM_CH  channel FIFO non-empty.
- ch_ready  in  NUM_CH  consumer pop; a pop happens when ch_valid[i] & ch_ready[i].
- busy  out  1  parser is not in HDR.
- hdr_err_cnt  out  16  count of rejected header words; saturates at 16'hFFFF.

## Operation
- Packet format: header word, then LEN payload words.
  - Header [31:28] = 4'hA (magic), [27:24] = CH, [23:16] ignored, [15:0] = LEN.
- Parser FSM states: HDR, PAYLOAD, DISCARD. Reset state is HDR. Only ep_write cycles advance the FSM.
- In HDR, on ep_write:
  - Magic mismatch: hdr_err_cnt increments and the FSM stays in HDR.
  - Magic ok, LEN = 0: no state change and no error.
  - Magic ok, CH < NUM_CH: latch CH and LEN into remaining, go to PAYLOAD.
  - Magic ok, CH >= NUM_CH: hdr_err_cnt increments, latch LEN, go to DISCARD.
- In PAYLOAD, on ep_write:
  - Push the word to FIFO[CH] and decrement remaining.
  - When remaining reaches 0 (last word), go to HDR.
- In DISCARD, on ep_write: drop the word and decrement remaining. The last word returns the FSM to HDR.
- FIFO write acceptance: the push is accepted if count < DEPTH, or if the same FIFO pops in the same cycle.
  - Otherwise the word is dropped, the overflow sticky ovf[CH] sets, and the FSM still decrements remaining.
- Each FIFO keeps a count of 0..DEPTH; simultaneous push and pop leave the count unchanged. Pops on an empty FIFO are ignored.
- Status word for channel k:
  - [31:28] = 4'h5, [27:24] = k, [23] = ovf[k], [22:16] = 0.
  - [15:0] = count[k], zero-extended; equals 16'h8000 only when DEPTH = 32768 and the FIFO is full.
- Status pointer rd_idx:
  - ep_read consumes the word for rd_idx and clears ovf[rd_idx] (clear-on-read).
  - rd_idx then advances, wrapping from NUM_CH-1 to 0.
  - If an overflow on channel rd_idx coincides with its clear, the set wins.
- ep_datain is refreshed every cycle from the current rd_idx, so the fill level is live.
- mst_reset, including mid-packet: FSM to HDR, all FIFOs empty, all ovf bits clear, rd_idx = 0, hdr_err_cnt = 0. Partial packets are lost; the host must resend from a header.

## Timing
- Reset values:
  - ch_valid = 0, ch_data = 0, busy = 0, hdr_err_cnt = 0.
  - ep_datain = 32'h5000_0000.
- Payload latency: a word accepted with ep_write in cycle N shows ch_valid=1 and ch_data = that word from cycle N+1, if the FIFO was empty.
- Pop: with ch_valid & ch_ready in cycle N, the next word (or ch_valid=0) appears in cycle N+1.
- busy is registered; it rises the cycle after an accepted header and falls the cycle after the last payload or discard word.
- ep_datain is registered; it reflects state from the previous cycle.
  - After ep_read in cycle N, ep_datain shows the next channel from N+1.
  - This meets the pipe-out rule that data be valid on the cycle following ep_read.
- hdr_err_cnt updates one cycle after the offending ep_write.
- The block sustains full rate: one ep_write and one ep_read per cycle, plus one pop per channel per cycle.

## Test plan
- Routing, NUM_CH=2, DEPTH=8: write header 32'hA100_0003, then 11, 22, 33.
  - ch_valid[1] rises one cycle after the word 11 write; popping yields 11, 22, 33 in order.
  - ch_valid[0] stays 0 and busy drops after the word 33 write.
- Overflow, DEPTH=8: send header 32'hA000_000A and 10 words 1..10 with ch_ready = 0.
  - FIFO0 holds 1..8 and words 9, 10 are dropped.
  - The status read for channel 0 returns 32'h5080_0008; the next read for channel 0 shows bit 23 = 0.
- Bad headers: write 32'h1234_5678, then 32'hA500_0002 with NUM_CH=2, followed by 2 words.
  - hdr_err_cnt = 2, both FIFOs stay empty, and the FSM returns to HDR.
  - A following good header is accepted.
- Status round-robin, NUM_CH=3: pulse ep_read 4 times.
  - ep_datain channel field sequence: 0, 1, 2, 0.
- Simultaneous events: on full FIFO0, pop and push in the same cycle.
  - The push is accepted, count stays 8, and ovf stays 0.
  - An overflow coinciding with an ep_read of channel 0 leaves ovf[0] = 1.
- Reset mid-packet: assert mst_reset after 2 of 5 payload words.
  - All outputs take their reset values asynchronously.
  - A new header with LEN = 1 plus one word routes correctly afterwards.
